i2c_bit_drv: RTL and testbench

- Bit-level I2C master line driver; the output-side counterpart of the SCL/SDA input synchronizer.
- Executes one bus primitive per command: START, STOP, WRITE bit or READ bit.
- Drives open-drain enables for SCL and SDA.
- Consumes the already-synchronized line levels to support clock stretching, bit sampling and arbitration-loss detection.
- Sits between the byte-level I2C master FSM and the pad/tristate logic.

---
 rtl/i2c_bit_drv.sv | 198 +++++++++++++++++++
 tb/tb_i2c_bit_drv.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_drv.sv
// Bit-level I2C master line driver: runs START/STOP/WRITE/READ as four timed phases.
// Optional SCL stretch timeout is compiled in with `define I2C_BIT_DRV_TIMEOUT_EN.
module i2c_bit_drv #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned TO_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd,
    input  logic             cmd_bit,
    output logic             rsp_vld,
    output logic             rsp_bit,
    output logic             arb_lost,
    output logic             timeout,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe,
    output logic             sda_oe
);
    typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;
    typedef enum logic [1:0] {
        OP_START = 2'b00,
        OP_STOP  = 2'b01,
        OP_WRITE = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;
    logic             fin_q, fin_d;
    logic             fin_arb_q, fin_arb_d;
    logic             fin_to_q, fin_to_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic             rsp_bit_q, rsp_bit_d;
    logic             arb_lost_q, arb_lost_d;
    logic             timeout_q, timeout_d;
    logic             waiting;
    logic             to_hit;

    if (TO_CYC == 0) begin : g_bad_to_cyc
        $error("TO_CYC must be nonzero");
    end

    // {scl_oe, sda_oe} for a given phase of a given opcode
    function automatic logic [1:0] lines(input state_t st, input op_t op, input logic b);
        logic scl, sda;
        scl = 1'b0;
        sda = 1'b0;
        case (op)
            OP_START: begin scl = (st == PH_D); sda = (st == PH_C) || (st == PH_D); end
            OP_STOP:  begin scl = (st == PH_A); sda = (st != PH_D); end
            OP_WRITE: begin scl = (st == PH_A) || (st == PH_D); sda = ~b; end
            default:  begin scl = (st == PH_A) || (st == PH_D); sda = 1'b0; end
        endcase
        return {scl, sda};
    endfunction

    // A released phase holds its counter at the load value until a slave lets SCL rise.
    always_comb begin
        waiting = (state_q != IDLE) && !scl_oe_q && (cnt_q == div_q) && !scl_i;
    end

`ifdef I2C_BIT_DRV_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        to_hit   = 1'b0;
        if (waiting) begin
            if (to_cnt_q == TO_W'(TO_CYC - 1)) to_hit = 1'b1;
            else                               to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    always_comb begin
        to_hit = 1'b0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bit_d      = bit_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        scl_oe_d   = scl_oe_q;
        sda_oe_d   = sda_oe_q;
        fin_d      = 1'b0;
        fin_arb_d  = 1'b0;
        fin_to_d   = 1'b0;
        rsp_vld_d  = fin_q;
        arb_lost_d = fin_arb_q;
        timeout_d  = fin_to_q;
        rsp_bit_d  = rsp_bit_q;

        if (cmd_vld && cmd_rdy) begin
            op_d    = op_t'(cmd);
            bit_d   = cmd_bit;
            div_d   = div;
            cnt_d   = div;
            state_d = PH_A;
        end else if (to_hit) begin
            state_d  = IDLE;
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
            fin_d    = 1'b1;
            fin_to_d = 1'b1;
        end else if (state_q != IDLE && !waiting) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DIV_W'(1);
            end else begin
                cnt_d = div_q;
                case (state_q)
                    PH_A: state_d = PH_B;
                    PH_B: state_d = PH_C;
                    PH_C: begin
                        rsp_bit_d = sda_i;
                        if (op_q == OP_WRITE && bit_q && !sda_i) begin
                            state_d   = IDLE;
                            scl_oe_d  = 1'b0;
                            sda_oe_d  = 1'b0;
                            fin_d     = 1'b1;
                            fin_arb_d = 1'b1;
                        end else begin
                            state_d = PH_D;
                        end
                    end
                    PH_D: begin
                        state_d = IDLE;
                        fin_d   = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Lines change together with the phase; IDLE keeps whatever was last driven.
        if (state_d != IDLE) {scl_oe_d, sda_oe_d} = lines(state_d, op_d, bit_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_START;
            bit_q      <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            fin_q      <= 1'b0;
            fin_arb_q  <= 1'b0;
            fin_to_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_bit_q  <= 1'b0;
            arb_lost_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            fin_q      <= fin_d;
            fin_arb_q  <= fin_arb_d;
            fin_to_q   <= fin_to_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_bit_q  <= rsp_bit_d;
            arb_lost_q <= arb_lost_d;
            timeout_q  <= timeout_d;
        end
    end

    // The cycle after a command finishes is spent staging the response pulse.
    assign cmd_rdy  = (state_q == IDLE) && !fin_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_bit  = rsp_bit_q;
    assign arb_lost = arb_lost_q;
    assign timeout  = timeout_q;
    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;

endmodule

// File: tb/tb_i2c_bit_drv.sv
// Scoreboard bench for i2c_bit_drv: open-drain bus model with a stretching slave and SDA forcing.
`timescale 1ns/1ps
module tb_i2c_bit_drv;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned TO_CYC = 20;
`ifdef I2C_BIT_DRV_TIMEOUT_EN
    localparam int STRETCH = 15;
`else
    localparam int STRETCH = 50;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] div;
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [1:0]       cmd;
    logic             cmd_bit;
    logic             rsp_vld;
    logic             rsp_bit;
    logic             arb_lost;
    logic             timeout;
    logic             scl_i;
    logic             sda_i;
    logic             scl_oe;
    logic             sda_oe;
    logic             slave_hold = 1'b0;
    logic             sda_force  = 1'b0;

    assign scl_i = ~scl_oe & ~slave_hold;
    assign sda_i = ~sda_oe & ~sda_force;

    i2c_bit_drv #(.DIV_W(DIV_W), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .div(div),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd(cmd), .cmd_bit(cmd_bit),
        .rsp_vld(rsp_vld), .rsp_bit(rsp_bit), .arb_lost(arb_lost), .timeout(timeout),
        .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic bit_v;
        logic chk_bit;
        logic arb;
        logic to;
        int   lat;
        int   acc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_cmd_rdy", cmd_rdy, 1);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_rsp_bit", rsp_bit, 0);
        check("rst_arb_lost", arb_lost, 0);
        check("rst_timeout", timeout, 0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic [1:0] op, input logic b, input logic [DIV_W-1:0] d,
                         input logic eb, input logic cb, input logic ea, input logic et,
                         input int lat, input logic b2b);
        exp_t e;
        logic ok;
        ok      = 1'b0;
        cmd     = op;
        cmd_bit = b;
        div     = d;
        cmd_vld = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_rdy) begin
                if (b2b) check("b2b_on_rsp", rsp_vld, 1);
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("cmd_accept", ok, 1);
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd     = ~op;
        cmd_bit = ~b;
        div     = d + DIV_W'(5);
        e.bit_v = eb; e.chk_bit = cb; e.arb = ea; e.to = et; e.lat = lat; e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_rsp(input int max_cyc);
        int n;
        n = 0;
        while (!rsp_vld && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen", rsp_vld, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_vld) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_vld, 0);
            end else begin
                e = sb.pop_front();
                if (e.chk_bit) check("rsp_bit", rsp_bit, e.bit_v);
                check("rsp_arb_lost", arb_lost, e.arb);
                check("rsp_timeout", timeout, e.to);
                check("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        int n;
        pat     = 8'b1100_0011;
        cmd_vld = 1'b0;
        cmd     = 2'b00;
        cmd_bit = 1'b0;
        div     = DIV_W'(3);

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        // START, div=3: SDA pulled from phase C, SCL from phase D
        issue(2'b00, 1'b0, DIV_W'(3), 1'b0, 1'b1, 1'b0, 1'b0, 17, 1'b0);
        for (int t = 0; t < 17; t++) begin
            check("start_scl", scl_oe, t >= 12);
            check("start_sda", sda_oe, t >= 8);
            check("start_rdy", cmd_rdy, 0);
            @(negedge clk);
        end
        check("start_rdy_on_rsp", cmd_rdy, 1);
        check("start_rsp_vld", rsp_vld, 1);
        @(negedge clk);

        // WRITE 0 then back-to-back READ, div=1
        issue(2'b10, 1'b0, DIV_W'(1), 1'b0, 1'b1, 1'b0, 1'b0, 9, 1'b0);
        for (int t = 0; t < 8; t++) begin
            check("wr_scl", scl_oe, pat[t]);
            check("wr_sda", sda_oe, 1);
            @(negedge clk);
        end
        issue(2'b11, 1'b0, DIV_W'(1), 1'b1, 1'b1, 1'b0, 1'b0, 9, 1'b1);
        for (int t = 0; t < 8; t++) begin
            check("rd_scl", scl_oe, pat[t]);
            check("rd_sda", sda_oe, 0);
            @(negedge clk);
        end
        wait_rsp(10);
        @(negedge clk);

        // WRITE 1 loses arbitration when SDA is held low in phase C
        issue(2'b10, 1'b1, DIV_W'(1), 1'b0, 1'b1, 1'b1, 1'b0, 7, 1'b0);
        repeat (3) @(negedge clk);
        sda_force = 1'b1;
        wait_rsp(20);
        check("arb_pulse", arb_lost, 1);
        check("arb_rdy", cmd_rdy, 1);
        sda_force = 1'b0;
        @(negedge clk);
        check("arb_scl_rel", scl_oe, 0);
        check("arb_sda_rel", sda_oe, 0);
        check("arb_rdy_next", cmd_rdy, 1);
        check("arb_pulse_end", arb_lost, 0);

        // READ with the slave stretching SCL after the driver releases it, div=2
        slave_hold = 1'b1;
        issue(2'b11, 1'b0, DIV_W'(2), 1'b1, 1'b1, 1'b0, 1'b0, 13 + STRETCH, 1'b0);
        n = 0;
        while (scl_oe && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stretch_scl_rel", scl_oe, 0);
        repeat (STRETCH) @(posedge clk);
        @(negedge clk);
        slave_hold = 1'b0;
        wait_rsp(100);
        @(negedge clk);

        // Reset in the middle of a WRITE drops it silently
        issue(2'b10, 1'b0, DIV_W'(3), 1'b0, 1'b1, 1'b0, 1'b0, 17, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        sb.delete();
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // STOP completes and leaves both lines released
        issue(2'b01, 1'b0, DIV_W'(3), 1'b0, 1'b1, 1'b0, 1'b0, 17, 1'b0);
        wait_rsp(40);
        @(negedge clk);
        check("stop_scl_rel", scl_oe, 0);
        check("stop_sda_rel", sda_oe, 0);

`ifdef I2C_BIT_DRV_TIMEOUT_EN
        // Slave never releases SCL: timeout after TO_CYC waiting cycles
        slave_hold = 1'b1;
        issue(2'b11, 1'b0, DIV_W'(0), 1'b0, 1'b0, 1'b0, 1'b1, TO_CYC + 2, 1'b0);
        wait_rsp(100);
        check("to_pulse", timeout, 1);
        @(negedge clk);
        check("to_scl_rel", scl_oe, 0);
        check("to_sda_rel", sda_oe, 0);
        slave_hold = 1'b0;
        @(negedge clk);
`endif

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
